data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data-memory controller: the successor to the MCU's single-cycle word RAM. It sits between the RV32I core's load/store port and an internal word array. It adds RV32I byte/halfword/word accesses, sign/zero extension, configurable wait states, and a req/ready handshake so the core can stall on memory.

## Interface
- `DEPTH`, default 64: number of 32-bit words. Must be a power of two, at least 4.
- `WAIT_STATES`, default 0: extra cycles inserted before each response. Range 0–15.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  access request. Sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data. The low byte or halfword is used for B/H.
- `rdata`  out  32  load result, extended per `funct3`. Valid while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  misaligned-access flag. Valid with `ready`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `req`=1:
  - Capture `we`, `funct3`, `addr`, `wdata`.
  - Go to RESP if `WAIT_STATES`=0. Otherwise load the wait counter with `WAIT_STATES` and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP.
- RESP: `ready`=1 for exactly one cycle, then return to IDLE.
- `req` is ignored in WAIT and RESP. The core does not need to hold request fields after the accept cycle.
- Word index is `addr[$clog2(DEPTH)+1:2]`. Upper address bits are ignored, so accesses wrap modulo DEPTH×4 bytes.
- Stores:
  - B writes lane `addr[1:0]` from `wdata[7:0]`.
  - H writes lane pair `addr[1]` from `wdata[15:0]`.
  - W writes all four bytes.
  - Lanes that are not selected keep their contents.
- Loads:
  - B/H sign-extend the selected lane(s); BU/HU zero-extend; W returns the word.
- Unused `funct3` codes (011, 110, 111): treated as W.
- Memory array contents are not cleared by reset.

## Timing
- Reset values: state IDLE, `ready`=0, `rdata`=0, `err`=0, wait counter 0.
- Latency from the accept edge to `ready` high is `WAIT_STATES`+1 cycles.
- Maximum throughput is one access per `WAIT_STATES`+2 cycles.
- The store commits to the array, and load data registers into `rdata`, on the clock edge that enters RESP. `rdata` holds its value after `ready` falls until the next load completes.
- For a store, `rdata` is unchanged.
- Reset asserted on any edge before entry to RESP aborts the access: no write, no `ready`.
- Reset during RESP forces IDLE. The write that already committed stays in the array.
- Read-after-write to the same address, issued in the next IDLE cycle, returns the new data.

## Configuration
- Macro: `DATA_MEM_MISALIGN_CHECK_EN`.
- Defined:
  - H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0, is misaligned.
  - A misaligned access still completes with normal latency, with `err`=1 alongside `ready`.
  - A misaligned store is suppressed.
  - A misaligned load returns `rdata`=0.
- Undefined:
  - `err` is tied to 0.
  - Misaligned low address bits are masked: H uses `addr[1]`, and W ignores `addr[1:0]`.

## Structure
- Package `data_mem_pkg` holds:
  - the `funct3` width enum (B, H, W, BU, HU);
  - the FSM state enum;
  - a localparam for the maximum `WAIT_STATES`.
- Sub-module `mem_byte_lane` is purely combinational and produces:
  - the store byte-enable mask and lane-shifted write data;
  - load lane selection plus sign/zero extension.

## Test plan
- Reset with `req`=1 held → `ready`, `rdata` and `err` stay 0. After release, the first accept happens on the next edge.
- `WAIT_STATES`=0:
  - SW 0xDEADBEEF @0x10, then LW @0x10 → `ready` one cycle after each accept, `rdata`=0xDEADBEEF.
- Lanes and extension:
  - SB 0x80 @0x13 after word 0x11223344, then LW → 0x80223344.
  - LB @0x13 → 0xFFFFFF80.
  - LBU @0x13 → 0x00000080.
  - SH 0xBEEF @0x12, then LH → 0xFFFFBEEF.
- `WAIT_STATES`=3 → `ready` exactly 4 cycles after accept. A `req` pulse during WAIT is ignored. A reset pulse during WAIT leaves the prior word unchanged.
- `DEPTH`=64: SW @0x100 then LW @0x000 → same data (wrap).
- With `DATA_MEM_MISALIGN_CHECK_EN`:
  - SW @0x11 → `err`=1, memory unchanged.
  - LH @0x11 → `err`=1, `rdata`=0.
- Without `DATA_MEM_MISALIGN_CHECK_EN`:
  - LW @0x11 returns the word at 0x10, `err`=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and limits for the data-memory controller
package data_mem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } width_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/mem_byte_lane.sv
// rtl/mem_byte_lane.sv - store lane steering and load lane extraction/extension
module mem_byte_lane
    import data_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic [31:0] storeData,
    input  logic [31:0] loadWord,
    output logic [3:0]  byteEn,
    output logic [31:0] laneData,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteEn   = 4'hf;
        laneData = storeData;
        loadData = loadWord;
        byteSel  = loadWord[{byteOff, 3'b000} +: 8];
        halfSel  = byteOff[1] ? loadWord[31:16] : loadWord[15:0];
        case (funct3)
            F3_B, F3_BU: begin
                byteEn   = 4'b0001 << byteOff;
                laneData = {4{storeData[7:0]}};
                loadData = (funct3 == F3_B) ? {{24{byteSel[7]}}, byteSel}
                                            : {24'b0, byteSel};
            end
            F3_H, F3_HU: begin
                // odd byte offset is simply masked; misalignment is judged by the caller
                byteEn   = byteOff[1] ? 4'b1100 : 4'b0011;
                laneData = {2{storeData[15:0]}};
                loadData = (funct3 == F3_H) ? {{16{halfSel[15]}}, halfSel}
                                            : {16'b0, halfSel};
            end
            default: begin
                byteEn = 4'hf;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32I load/store word-array controller with wait states
// Optional misalignment checking: DATA_MEM_MISALIGN_CHECK_EN
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_e             state, nextState;
    logic [CNT_W-1:0]   waitCnt;
    logic               capWe;
    logic [2:0]         capF3;
    logic [IDX_W+1:0]   capAddr;
    logic [31:0]        capWdata;

    logic               accWe;
    logic [2:0]         accF3;
    logic [IDX_W+1:0]   accAddr;
    logic [31:0]        accWdata;
    logic               enterResp;
    logic               misaligned;
    logic [3:0]         byteEn;
    logic [31:0]        laneData;
    logic [31:0]        loadData;
    logic [31:0]        mem [DEPTH];
    logic               unusedAddrBits;

    assign unusedAddrBits = ^addr[31:IDX_W+2];

    // with zero wait states the commit edge is the accept edge, so use the live inputs
    assign accWe    = (state == ST_IDLE) ? we             : capWe;
    assign accF3    = (state == ST_IDLE) ? funct3         : capF3;
    assign accAddr  = (state == ST_IDLE) ? addr[IDX_W+1:0] : capAddr;
    assign accWdata = (state == ST_IDLE) ? wdata          : capWdata;
    assign enterResp = (nextState == ST_RESP) && (state != ST_RESP);

`ifdef DATA_MEM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (accF3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = accAddr[0];
            default:     misaligned = |accAddr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    mem_byte_lane u_lane (
        .funct3    (accF3),
        .byteOff   (accAddr[1:0]),
        .storeData (accWdata),
        .loadWord  (mem[accAddr[IDX_W+1:2]]),
        .byteEn    (byteEn),
        .laneData  (laneData),
        .loadData  (loadData)
    );

    always_comb begin
        nextState = state;
        ready     = 1'b0;
        case (state)
            ST_IDLE: if (req) nextState = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (waitCnt == CNT_W'(1)) nextState = ST_RESP;
            ST_RESP: begin
                ready     = 1'b1;
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            waitCnt  <= '0;
            capWe    <= 1'b0;
            capF3    <= 3'b000;
            capAddr  <= '0;
            capWdata <= '0;
            rdata    <= '0;
            err      <= 1'b0;
        end else begin
            state <= nextState;
            if (state == ST_IDLE && req) begin
                capWe    <= we;
                capF3    <= funct3;
                capAddr  <= addr[IDX_W+1:0];
                capWdata <= wdata;
                waitCnt  <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (enterResp) begin
                err <= misaligned;
                if (!accWe) rdata <= misaligned ? 32'b0 : loadData;
            end
        end
    end

    // array is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (!reset && enterResp && accWe && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[accAddr[IDX_W+1:2]][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - bench for data_mem_ctrl at zero and three wait states
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req3, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, err0, err3;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mb [2][256];
    logic [31:0] lastR [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    data_mem_ctrl #(.DEPTH(64), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // byte-addressed reference: 64 words = 256 bytes, address wraps
    function automatic void modelAccess(input int d, input bit w, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        output logic [31:0] r, output logic e);
        int size, ba, base;
        logic [31:0] v;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        ba   = int'(a[7:0]);
        base = ba - (ba % size);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        e = ((ba % size) != 0);
`else
        e = 1'b0;
`endif
        if (w) begin
            if (!e) for (int i = 0; i < size; i++) mb[d][base + i] = wd[8*i +: 8];
            r = lastR[d];
        end else begin
            v = 32'b0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mb[d][base + i];
            if (e)              r = 32'b0;
            else if (size == 1) r = (f3 == 3'd0) ? {{24{v[7]}}, v[7:0]} : v;
            else if (size == 2) r = (f3 == 3'd1) ? {{16{v[15]}}, v[15:0]} : v;
            else                r = v;
            lastR[d] = r;
        end
    endfunction

    task automatic doAccess(input bit w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] obs0);
        logic [31:0] exp0, exp3;
        logic e0, e3;
        int c0, c3;
        modelAccess(0, w, f3, a, wd, exp0, e0);
        modelAccess(1, w, f3, a, wd, exp3, e3);
        obs0 = 'x;
        reset = 1'b0; we = w; funct3 = f3; addr = a; wdata = wd;
        req0 = 1'b1; req3 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        c0 = 0; c3 = 0;
        for (int cyc = 1; cyc <= 12 && c3 == 0; cyc++) begin
            @(negedge clk);
            if (ready0 && c0 == 0) begin
                c0 = cyc; obs0 = rdata0;
                check("rdata_ws0", rdata0, exp0);
                check("err_ws0", 32'(err0), 32'(e0));
            end
            if (cyc == 2) check("ready_pulse_ws0", 32'(ready0), 0);
            if (ready3) begin
                c3 = cyc;
                check("rdata_ws3", rdata3, exp3);
                check("err_ws3", 32'(err3), 32'(e3));
            end
            req3 = (cyc == 2);
        end
        req3 = 1'b0;
        check("latency_ws0", c0, 1);
        check("latency_ws3", c3, 4);
        @(negedge clk);
        check("ready_pulse_ws3", 32'(ready3), 0);
    endtask

    logic [31:0] o, rw, re;
    logic        ee;

    initial begin
        reset = 1'b1; req0 = 1'b1; req3 = 1'b1; we = 1'b1; funct3 = 3'b010;
        addr = 32'h10; wdata = 32'hDEADBEEF;
        lastR[0] = 32'b0; lastR[1] = 32'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_ready", {ready3, ready0}, 0);
            check("reset_rdata0", rdata0, 0);
            check("reset_rdata3", rdata3, 0);
            check("reset_err", {err3, err0}, 0);
        end

        doAccess(1, 3'b010, 32'h10, 32'hDEADBEEF, o);
        doAccess(0, 3'b010, 32'h10, 32'h0, o);
        check("sw_lw", o, 32'hDEADBEEF);

        for (int i = 0; i < 64; i++) doAccess(1, 3'b010, 32'(i * 4), $urandom, o);

        doAccess(1, 3'b010, 32'h10, 32'h11223344, o);
        doAccess(1, 3'b000, 32'h13, 32'h00000080, o);
        doAccess(0, 3'b010, 32'h10, 32'h0, o);
        check("sb_lw", o, 32'h80223344);
        doAccess(0, 3'b000, 32'h13, 32'h0, o);
        check("lb", o, 32'hFFFFFF80);
        doAccess(0, 3'b100, 32'h13, 32'h0, o);
        check("lbu", o, 32'h00000080);
        doAccess(1, 3'b001, 32'h12, 32'h0000BEEF, o);
        doAccess(0, 3'b001, 32'h12, 32'h0, o);
        check("sh_lh", o, 32'hFFFFBEEF);

        rw = $urandom;
        doAccess(1, 3'b010, 32'h100, rw, o);
        doAccess(0, 3'b010, 32'h000, 32'h0, o);
        check("wrap", o, rw);

        doAccess(1, 3'b010, 32'h10, 32'h55667788, o);
        doAccess(1, 3'b010, 32'h11, 32'hCAFEF00D, o);
        doAccess(0, 3'b010, 32'h10, 32'h0, o);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        check("misaligned_sw_suppressed", o, 32'h55667788);
        doAccess(0, 3'b001, 32'h11, 32'h0, o);
        check("misaligned_lh_zero", o, 32'h0);
`else
        check("masked_sw", o, 32'hCAFEF00D);
        doAccess(0, 3'b010, 32'h11, 32'h0, o);
        check("masked_lw", o, 32'hCAFEF00D);
`endif

        // reset during the three-cycle wait aborts only the slow instance's store
        rw = $urandom;
        modelAccess(0, 1, 3'b010, 32'h20, rw, re, ee);
        we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = rw;
        req0 = 1'b1; req3 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        @(negedge clk);
        check("abort_ws0_ready", 32'(ready0), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rdata3", rdata3, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(ready3), 0);
        end
        lastR[0] = 32'b0; lastR[1] = 32'b0;
        doAccess(0, 3'b010, 32'h20, 32'h0, o);
        check("abort_ws0_committed", o, rw);

        for (int i = 0; i < 200; i++)
            doAccess(1'($urandom), 3'($urandom), $urandom, $urandom, o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
